b1_scfifo_reader: RTL

Read-side adapter for the single-clock FIFO in normal (non-showahead) mode. It issues read requests to the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words as a valid/ready stream at up to one word per clock. An optional packet framer marks every PKT_LEN-th word with `last_o`. It sits between a FIFO's read port and any downstream stream consumer.

---
 rtl/b1_scfifo_reader.sv | 71 +++++++
 1 files changed

// File: rtl/b1_scfifo_reader.sv
// Read-side adapter for a normal-mode single-clock FIFO: issues reads,
// absorbs the one-cycle read latency in a 2-entry buffer, emits a stream.
module b1_scfifo_reader #(
    parameter int DWIDTH  = 8,
    parameter int PKT_LEN = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic [1:0]        level_o
);
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PKT_LEN - 1);

    logic [1:0]        occ;
    logic              pend;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] tail;
    logic [PW-1:0]     pcnt;
    logic              out_fire;
    logic [2:0]        committed;

    assign valid_o   = (occ != 2'd0);
    assign out_fire  = valid_o & ready_i;
    assign data_o    = head;
    assign last_o    = valid_o & (pcnt == PLAST);
    assign level_o   = occ;

    // Slots already owned (buffered + in flight) after this cycle's pop.
    assign committed = {1'b0, occ} + {2'b00, pend} - {2'b00, out_fire};
    assign fifo_rdreq_o = arst_n_i & ~fifo_empty_i & (committed < 3'd2);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            occ  <= 2'd0;
            pend <= 1'b0;
            head <= '0;
            tail <= '0;
            pcnt <= '0;
        end else begin
            pend <= fifo_rdreq_o;
            occ  <= occ + {1'b0, pend} - {1'b0, out_fire};
            if (out_fire) begin
                pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
            end
            case ({pend, out_fire})
                2'b10: begin
                    if (occ == 2'd0) head <= fifo_q_i;
                    else             tail <= fifo_q_i;
                end
                2'b01: head <= tail;
                2'b11: begin
                    // With one word buffered the landing word becomes head.
                    if (occ == 2'd1) begin
                        head <= fifo_q_i;
                    end else begin
                        head <= tail;
                        tail <= fifo_q_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
